// File: rtl/arm_rf_pkg.sv
// ---------------------------------------------------------------------------
// arm_rf_pkg
// Shared defaults and types for the ARM pipeline register file.
//   DEF_DATA_W   : default register width
//   DEF_NUM_REGS : default number of architectural registers
//   DEF_ADDR_W   : index width derived from DEF_NUM_REGS
//   reg_idx_t    : register index type at default sizing
//   word_t       : register data word at default sizing
// ---------------------------------------------------------------------------
package arm_rf_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/rf_sb_counter.sv
// ---------------------------------------------------------------------------
// rf_sb_counter
// Pending-write counter for one architectural register.
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the count
//   inc     : an issued instruction will write this register
//   dec0    : write port 0 retires a write to this register
//   dec1    : write port 1 retires a write to this register
//   flush   : discard all pending writes (a same-cycle inc still counts)
//   cnt     : current outstanding-write count
//   sat_err : combinational pulse, issue attempted while saturated
// ---------------------------------------------------------------------------
module rf_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec0,
    input  logic             dec1,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             sat_err
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   up;
    logic [CNT_W:0]   dn;
    logic [CNT_W:0]   net;

    always_comb begin
        up      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
        dn      = {{CNT_W{1'b0}}, dec0} + {{CNT_W{1'b0}}, dec1};
        net     = up - dn;
        cnt_d   = cnt_q;
        sat_err = 1'b0;
        if (flush) begin
            cnt_d    = '0;
            cnt_d[0] = inc;
        end else if (up < dn) begin
            // write-backs of untracked writes clamp at zero silently
            cnt_d = '0;
        end else if (net > CNT_MAX) begin
            // only reachable as inc on a full counter with no retiring write
            cnt_d   = cnt_q;
            sat_err = 1'b1;
        end else begin
            cnt_d = net[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Multi-read, dual-write register file with a per-register pending-write
// scoreboard for the ID/WB boundary of the ARM pipeline.
//   clk        : clock, all state changes on posedge
//   rst        : asynchronous reset, active-low; reg i <= i, counts <= 0
//   rd_addr    : packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    : packed combinational read data
//   rd_busy    : per read port, register has an outstanding write
//   wb0_*      : write port 0 (main result), wins on address conflict
//   wb1_*      : write port 1 (base-register writeback)
//   issue_*    : mark issue_addr as having one more pending write
//   flush      : clear all pending counts
//   sb_err     : sticky, issue attempted on a saturated counter
// ---------------------------------------------------------------------------
module reg_file_sb
    import arm_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 3,
    parameter int CNT_W    = 2,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic                     sb_err
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [CNT_W-1:0]    cnt_all [NUM_REGS];
    logic [NUM_REGS-1:0] hit0;
    logic [NUM_REGS-1:0] hit1;
    logic [NUM_REGS-1:0] hit_iss;
    logic [NUM_REGS-1:0] err_vec;
    logic                sb_err_q;
    logic                sb_err_d;

    // One-hot decode; indices >= NUM_REGS match nothing and are ignored.
    always_comb begin
        hit0    = '0;
        hit1    = '0;
        hit_iss = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            hit0[r]    = wb0_en   && (wb0_addr   == ADDR_W'(r));
            hit1[r]    = wb1_en   && (wb1_addr   == ADDR_W'(r));
            hit_iss[r] = issue_en && (issue_addr == ADDR_W'(r));
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (hit0[r]) begin
                regs_d[r] = wb0_data;
            end else if (hit1[r]) begin
                regs_d[r] = wb1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= DATA_W'(r);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        rf_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst),
            .inc     (hit_iss[g]),
            .dec0    (hit0[g]),
            .dec1    (hit1[g]),
            .flush   (flush),
            .cnt     (cnt_all[g]),
            .sat_err (err_vec[g])
        );
    end

    // A saturated issue during flush is not an error: the flush empties it.
    always_comb begin
        sb_err_d = sb_err_q | ((|err_vec) & ~flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    // Read mux; out-of-range indices fall through to zero data, not busy.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] word;
        int                nhit;
        rd_data = '0;
        rd_busy = '0;
        a       = '0;
        word    = '0;
        nhit    = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            for (int r = 0; r < NUM_REGS; r++) begin
                if (a == ADDR_W'(r)) begin
                    word = regs_q[r];
                    nhit = int'(hit0[r]) + int'(hit1[r]);
                    if (BYPASS) begin
                        if (hit0[r]) begin
                            word = wb0_data;
                        end else if (hit1[r]) begin
                            word = wb1_data;
                        end
                        // writes retiring this cycle no longer make the reader wait
                        rd_busy[k] = int'(cnt_all[r]) > nhit;
                    end else begin
                        rd_busy[k] = cnt_all[r] != '0;
                    end
                    rd_data[k*DATA_W +: DATA_W] = word;
                end
            end
        end
    end

endmodule
